// File: rtl/range_pkg.sv
//------------------------------------------------------------------------------
// Module  : range_pkg
// Brief   : Shared state encoding and window-size legality check for the
//           RangeFinder window scheduler.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package range_pkg;

  typedef enum logic [2:0] {
    RS_IDLE  = 3'd0,
    RS_FILL  = 3'd1,
    RS_ABORT = 3'd2,
    RS_DRAIN = 3'd3,
    RS_FAULT = 3'd4
  } rs_state_t;

  localparam int c_win_min = 2;
  localparam int c_win_max = 255;

  // A one-sample window would need go and finish together, which the RangeFinder rejects.
  function automatic bit win_legal(input int win);
    return (win >= c_win_min) && (win <= c_win_max);
  endfunction

endpackage

`default_nettype wire

// File: rtl/range_result_slot.sv
//------------------------------------------------------------------------------
// Module  : range_result_slot
// Brief   : One-entry valid/ready result register; data holds after a pop.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module range_result_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_data  <= load_data;
      r_valid <= 1'b1;
    end else if (pop && r_valid) begin
      r_valid <= 1'b0;
    end
  end

  assign data  = r_data;
  assign valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/range_window_sched.sv
//------------------------------------------------------------------------------
// Module  : range_window_sched
// Brief   : Sequences one RangeFinder over fixed WIN-sample windows and stores
//           each window's range in a one-entry result slot.
//           Optional RANGE_SCHED_STATS_EN adds win_count / drop_count outputs.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module range_window_sched
  import range_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WIN   = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic [WIDTH-1:0] result_data,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             fault,
  output logic [WIDTH-1:0] rf_data,
  output logic             rf_go,
  output logic             rf_finish,
  input  logic [WIDTH-1:0] rf_range,
  input  logic             rf_error
`ifdef RANGE_SCHED_STATS_EN
  ,
  output logic [15:0]      win_count,
  output logic [7:0]       drop_count
`endif
);

  localparam int CNT_W = $clog2(WIN);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIN - 1);

  if (!win_legal(WIN)) begin : g_win_check
    $error("range_window_sched: WIN must be within 2..255");
  end

  rs_state_t        r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [WIDTH-1:0] r_held, w_held_next;
  logic             r_discard, w_discard_next;
  logic             w_ready, w_go, w_fin, w_load, w_drain;
  logic [WIDTH-1:0] w_data;
  logic             w_slot_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= RS_IDLE;
      r_cnt     <= '0;
      r_held    <= '0;
      r_discard <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_held    <= w_held_next;
      r_discard <= w_discard_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_held_next    = r_held;
    w_discard_next = r_discard;
    w_ready        = 1'b0;
    w_go           = 1'b0;
    w_fin          = 1'b0;
    w_load         = 1'b0;
    w_drain        = 1'b0;
    w_data         = r_held;

    case (r_state)
      RS_IDLE: begin
        // A new window only starts once its result has somewhere to go.
        w_ready = !w_slot_valid || result_ready;
        if (in_valid && w_ready) begin
          w_go         = 1'b1;
          w_data       = in_data;
          w_held_next  = in_data;
          w_cnt_next   = CNT_W'(1);
          w_state_next = RS_FILL;
        end
      end
      RS_FILL: begin
        if (abort) begin
          w_discard_next = 1'b1;
          w_state_next   = RS_ABORT;
        end else begin
          w_ready = 1'b1;
          if (in_valid) begin
            w_data      = in_data;
            w_held_next = in_data;
            if (r_cnt == c_last) begin
              w_fin        = 1'b1;
              w_state_next = RS_DRAIN;
            end else begin
              w_cnt_next = r_cnt + 1'b1;
            end
          end
        end
      end
      RS_ABORT: begin
        // Finishing on the held sample closes the window without moving min/max.
        w_fin        = 1'b1;
        w_state_next = RS_DRAIN;
      end
      RS_DRAIN: begin
        w_drain        = 1'b1;
        w_load         = !r_discard;
        w_discard_next = 1'b0;
        w_state_next   = RS_IDLE;
      end
      RS_FAULT: begin
        w_state_next = RS_FAULT;
      end
      default: begin
        w_state_next = RS_IDLE;
      end
    endcase

    if (rf_error) begin
      w_state_next   = RS_FAULT;
      w_cnt_next     = r_cnt;
      w_held_next    = r_held;
      w_discard_next = r_discard;
      w_ready        = 1'b0;
      w_go           = 1'b0;
      w_fin          = 1'b0;
      w_load         = 1'b0;
      w_drain        = 1'b0;
      w_data         = r_held;
    end
  end

  range_result_slot #(
    .WIDTH (WIDTH)
  ) u_slot (
    .clock     (clock),
    .reset     (reset),
    .load      (w_load),
    .load_data (rf_range),
    .pop       (result_ready),
    .data      (result_data),
    .valid     (w_slot_valid)
  );

  assign result_valid = w_slot_valid;
  assign in_ready     = w_ready && !reset;
  assign rf_data      = w_data;
  assign rf_go        = w_go;
  assign rf_finish    = w_fin;
  assign fault        = (r_state == RS_FAULT);

`ifdef RANGE_SCHED_STATS_EN
  logic [15:0] r_win_count;
  logic [7:0]  r_drop_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_win_count  <= '0;
      r_drop_count <= '0;
    end else if (w_drain) begin
      if (!r_discard) begin
        r_win_count <= r_win_count + 16'd1;
      end else if (r_drop_count != 8'hFF) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  assign win_count  = r_win_count;
  assign drop_count = r_drop_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_range_window_sched.sv
//------------------------------------------------------------------------------
// Module  : tb_range_window_sched
// Brief   : Directed bench for range_window_sched with a behavioural RangeFinder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_range_window_sched;

  logic       clock;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       abort;
  logic [7:0] result_data;
  logic       result_valid;
  logic       result_ready;
  logic       fault;
  logic [7:0] rf_data;
  logic       rf_go;
  logic       rf_finish;
  logic [7:0] rf_range;
  logic       rf_error;
`ifdef RANGE_SCHED_STATS_EN
  logic [15:0] win_count;
  logic [7:0]  drop_count;
`endif

  int vectors;
  int miscompares;

  range_window_sched #(
    .WIDTH (8),
    .WIN   (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .abort        (abort),
    .result_data  (result_data),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .fault        (fault),
    .rf_data      (rf_data),
    .rf_go        (rf_go),
    .rf_finish    (rf_finish),
    .rf_range     (rf_range),
    .rf_error     (rf_error)
`ifdef RANGE_SCHED_STATS_EN
    ,
    .win_count    (win_count),
    .drop_count   (drop_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural RangeFinder: go loads the first sample, finish folds in the last
  // one and registers max-min; protocol violations raise a sticky error.
  logic       m_run;
  logic       m_err;
  logic       force_err;
  logic [7:0] m_max, m_min;

  function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m_run    <= 1'b0;
      m_err    <= 1'b0;
      m_max    <= '0;
      m_min    <= '0;
      rf_range <= '0;
    end else begin
      if ((rf_go && rf_finish) || (rf_go && m_run) || (rf_finish && !m_run))
        m_err <= 1'b1;
      if (rf_go) begin
        m_run <= 1'b1;
        m_max <= rf_data;
        m_min <= rf_data;
      end else if (m_run) begin
        if (rf_finish) begin
          rf_range <= max8(m_max, rf_data) - min8(m_min, rf_data);
          m_run    <= 1'b0;
        end else begin
          m_max <= max8(m_max, rf_data);
          m_min <= min8(m_min, rf_data);
        end
      end
    end
  end

  assign rf_error = m_err | force_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic feed(input logic [7:0] s, input logic exp_go, input logic exp_fin);
    int n;
    n        = 0;
    in_data  = s;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    check("feed_in_ready", in_ready, 1);
    check("feed_rf_go", rf_go, exp_go);
    check("feed_rf_finish", rf_finish, exp_fin);
    check("feed_rf_data", rf_data, s);
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_win(input logic [7:0] s0, input logic [7:0] s1,
                         input logic [7:0] s2, input logic [7:0] s3,
                         input logic [7:0] exp);
    feed(s0, 1'b1, 1'b0);
    feed(s1, 1'b0, 1'b0);
    feed(s2, 1'b0, 1'b0);
    feed(s3, 1'b0, 1'b1);
    check("drain_in_ready", in_ready, 0);
    check("drain_result_valid", result_valid, 0);
    step();
    check("win_result_valid", result_valid, 1);
    check("win_result_data", result_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors      = 0;
    miscompares  = 0;
    reset        = 1'b1;
    in_data      = '0;
    in_valid     = 1'b0;
    abort        = 1'b0;
    result_ready = 1'b1;
    force_err    = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_result_data", result_data, 0);
    check("rst_fault", fault, 0);
    check("rst_rf_go", rf_go, 0);
    check("rst_rf_finish", rf_finish, 0);
    check("rst_rf_data", rf_data, 0);
    step();
    step();
    reset = 1'b0;
    #1;

    // Window 1, with one idle cycle in FILL to confirm the strobes stay low.
    feed(8'd10, 1'b1, 1'b0);
    check("gap_rf_go", rf_go, 0);
    check("gap_rf_finish", rf_finish, 0);
    check("gap_rf_data", rf_data, 10);
    step();
    feed(8'd3, 1'b0, 1'b0);
    feed(8'd25, 1'b0, 1'b0);
    feed(8'd7, 1'b0, 1'b1);
    check("w1_drain_in_ready", in_ready, 0);
    check("w1_n1_result_valid", result_valid, 0);
    step();
    check("w1_result_valid", result_valid, 1);
    check("w1_result_data", result_data, 22);

    run_win(8'd5, 8'd5, 8'd5, 8'd5, 8'd0);
    run_win(8'd0, 8'd255, 8'd128, 8'd1, 8'd255);

    // Backpressure: slot full and not popped holds off the next window.
    step();
    result_ready = 1'b0;
    run_win(8'd10, 8'd3, 8'd25, 8'd7, 8'd22);
    in_data  = 8'd5;
    in_valid = 1'b1;
    #1;
    check("bp_in_ready_0", in_ready, 0);
    step();
    check("bp_in_ready_1", in_ready, 0);
    check("bp_result_valid", result_valid, 1);
    result_ready = 1'b1;
    #1;
    check("bp_pop_in_ready", in_ready, 1);
    check("bp_pop_rf_go", rf_go, 1);
    step();
    in_valid = 1'b0;
    check("bp_popped", result_valid, 0);
    feed(8'd6, 1'b0, 1'b0);
    feed(8'd7, 1'b0, 1'b0);
    feed(8'd9, 1'b0, 1'b1);
    step();
    check("bp_result_valid2", result_valid, 1);
    check("bp_result_data", result_data, 4);

    // Abort wins over a valid sample; the window is discarded.
    feed(8'd5, 1'b1, 1'b0);
    feed(8'd9, 1'b0, 1'b0);
    in_data  = 8'd99;
    in_valid = 1'b1;
    abort    = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 0);
    check("abort_rf_finish_fill", rf_finish, 0);
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("abort_rf_finish", rf_finish, 1);
    check("abort_rf_data", rf_data, 9);
    check("abort_state_in_ready", in_ready, 0);
    step();
    check("abort_drain_in_ready", in_ready, 0);
    step();
    check("abort_no_result", result_valid, 0);
    check("abort_data_held", result_data, 4);
    run_win(8'd1, 8'd2, 8'd3, 8'd4, 8'd3);
    check("abort_fault", fault, 0);

    // Reset in the middle of a window.
    feed(8'd1, 1'b1, 1'b0);
    feed(8'd2, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_result_valid", result_valid, 0);
    check("mid_rst_result_data", result_data, 0);
    check("mid_rst_rf_go", rf_go, 0);
    check("mid_rst_fault", fault, 0);
    step();
    reset = 1'b0;
    #1;
    run_win(8'd8, 8'd2, 8'd6, 8'd4, 8'd6);

    // RangeFinder error while filling.
    feed(8'd1, 1'b1, 1'b0);
    force_err = 1'b1;
    step();
    force_err = 1'b0;
    in_data   = 8'd2;
    in_valid  = 1'b1;
    #1;
    check("fault_set", fault, 1);
    check("fault_in_ready", in_ready, 0);
    check("fault_rf_go", rf_go, 0);
    step();
    step();
    check("fault_sticky", fault, 1);
    check("fault_in_ready_hold", in_ready, 0);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    step();
    reset = 1'b0;
    #1;
    check("fault_cleared", fault, 0);

`ifdef RANGE_SCHED_STATS_EN
    feed(8'd1, 1'b1, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    step();
    step();
    run_win(8'd1, 8'd2, 8'd3, 8'd4, 8'd3);
    run_win(8'd9, 8'd2, 8'd3, 8'd4, 8'd7);
    run_win(8'd0, 8'd2, 8'd3, 8'd40, 8'd40);
    check("stats_win_count", win_count, 3);
    check("stats_drop_count", drop_count, 1);
`endif

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
